// File: rtl/sprite_renderer_pkg.sv
// -----------------------------------------------------------------------------
// sprite_renderer_pkg
//
// Purpose:
//   Shared definitions for the sprite renderer: screen geometry, coordinate and
//   colour widths, and the renderer state encoding.
//
// Contents:
//   SCREEN_W, SCREEN_H : visible screen size in pixels (160 x 120)
//   X_W, Y_W           : pixel coordinate widths (8 and 7 bits)
//   W_W                : square width field width (4 bits)
//   COLOUR_W           : pixel colour width (3 bits)
//   state_t            : IDLE / ERASE / DRAW
// -----------------------------------------------------------------------------
package sprite_renderer_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int W_W      = 4;
   localparam int COLOUR_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DRAW  = 2'd2
   } state_t;

endpackage

// File: rtl/sprite_renderer_square_scanner.sv
// -----------------------------------------------------------------------------
// square_scanner
//
// Purpose:
//   Row-major pixel counter over a width x width square. px is the inner
//   (column) index, py the outer (row) index. The counter wraps back to (0,0)
//   on the step that consumes the last pixel, so a following square can start
//   on the very next granted cycle without an explicit restart.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   start    in   hold the counter at (0,0)
//   advance  in   consume the current pixel (granted step)
//   width    in   square width; must be non-zero while scanning
//   px, py   out  current pixel offset inside the square
//   last     out  current pixel is the final one of the square
// -----------------------------------------------------------------------------
module square_scanner
   import sprite_renderer_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           advance,
   input  logic [W_W-1:0] width,
   output logic [W_W-1:0] px,
   output logic [W_W-1:0] py,
   output logic           last
);

   logic [W_W-1:0] width_m1;
   logic           row_end;

   assign width_m1 = width - W_W'(1);
   assign row_end  = (px == width_m1);
   assign last     = row_end && (py == width_m1);

   always_ff @(posedge clk) begin
      if (reset || start) begin
         px <= '0;
         py <= '0;
      end else if (advance) begin
         if (last) begin
            px <= '0;
            py <= '0;
         end else if (row_end) begin
            px <= '0;
            py <= py + W_W'(1);
         end else begin
            px <= px + W_W'(1);
         end
      end
   end

endmodule

// File: rtl/sprite_renderer.sv
// -----------------------------------------------------------------------------
// sprite_renderer
//
// Purpose:
//   Turns an object's position/width and move/load pulses into VGA pixel
//   writes. A move erases the previously drawn square in BG_COLOUR and then
//   draws the square at the new position in COLOUR. load_level draws without
//   erasing. The VGA port is shared with other renderers through an external
//   req/gnt arbiter; a pixel is only issued on a cycle with req && gnt.
//
// Parameters:
//   COLOUR     sprite pixel colour
//   BG_COLOUR  erase colour
//   MAX_W      widths above this are clamped to it
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   move        in   pulse: object position changed (erase + draw)
//   load_level  in   pulse: draw at current position, no erase
//   obj_x/y/w   in   object top-left and width (w=0: not drawn)
//   gnt         in   arbiter grant for the current cycle
//   req         out  VGA port request (ERASE or DRAW)
//   busy        out  renderer not idle
//   vga_x/y     out  registered pixel address
//   vga_colour  out  registered pixel colour
//   plot        out  write strobe aligned with the registered pixel
//
// Build option:
//   SPRITE_RENDER_SKIP_EN - a move to exactly the already drawn position and
//   width is dropped after one busy cycle, with no req and no plot.
// -----------------------------------------------------------------------------
module sprite_renderer
   import sprite_renderer_pkg::*;
#(
   parameter logic [COLOUR_W-1:0] COLOUR    = 3'b111,
   parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000,
   parameter int                  MAX_W     = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                move,
   input  logic                load_level,
   input  logic [X_W-1:0]      obj_x,
   input  logic [Y_W-1:0]      obj_y,
   input  logic [W_W-1:0]      obj_w,
   input  logic                gnt,
   output logic                req,
   output logic                busy,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                plot
);

   function automatic logic [W_W-1:0] clamp_w(input logic [W_W-1:0] w);
      if (int'(w) > MAX_W) return W_W'(MAX_W);
      return w;
   endfunction

   state_t         state;

   logic [X_W-1:0] new_x, old_x;
   logic [Y_W-1:0] new_y, old_y;
   logic [W_W-1:0] new_w, old_w;
   logic           old_valid;
   logic           pending;

   logic [W_W-1:0] lat_w;
   logic           event_in;
   logic           step;
   logic           done;

   logic [W_W-1:0] scan_w;
   logic [W_W-1:0] px, py;
   logic           last;

   logic [X_W-1:0] base_x;
   logic [Y_W-1:0] base_y;
   logic [X_W:0]   pix_x;
   logic [Y_W:0]   pix_y;
   logic           in_bounds;

`ifdef SPRITE_RENDER_SKIP_EN
   logic           skip_busy;
   logic           skip_match;

   assign skip_match = old_valid && (obj_x == old_x) && (obj_y == old_y) &&
                       (lat_w == old_w);
   assign busy       = (state != IDLE) || skip_busy;
`else
   assign busy       = (state != IDLE);
`endif

   assign req      = (state == ERASE) || (state == DRAW);
   assign lat_w    = clamp_w(obj_w);
   assign event_in = move || load_level;
   assign step     = req && gnt;

   // Job completes on the last DRAW pixel, or on the last ERASE pixel when
   // there is nothing to draw afterwards.
   assign done = step && last &&
                 ((state == DRAW) || ((state == ERASE) && (new_w == '0)));

   assign scan_w = (state == ERASE) ? old_w : new_w;
   assign base_x = (state == ERASE) ? old_x : new_x;
   assign base_y = (state == ERASE) ? old_y : new_y;

   // One extra bit on each axis so squares hanging off the right/bottom edge
   // are clipped rather than wrapping around to column/row 0.
   assign pix_x     = {1'b0, base_x} + {{(X_W + 1 - W_W){1'b0}}, px};
   assign pix_y     = {1'b0, base_y} + {{(Y_W + 1 - W_W){1'b0}}, py};
   assign in_bounds = (pix_x < (X_W + 1)'(SCREEN_W)) &&
                      (pix_y < (Y_W + 1)'(SCREEN_H));

   square_scanner u_scanner (
      .clk     (clk),
      .reset   (reset),
      .start   (state == IDLE),
      .advance (step),
      .width   (scan_w),
      .px      (px),
      .py      (py),
      .last    (last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         plot       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         pending    <= 1'b0;
         old_valid  <= 1'b0;
         old_x      <= '0;
         old_y      <= '0;
         old_w      <= '0;
         new_x      <= '0;
         new_y      <= '0;
         new_w      <= '0;
`ifdef SPRITE_RENDER_SKIP_EN
         skip_busy  <= 1'b0;
`endif
      end else begin
         // Pixel output stage: registered on a granted step, strobe follows.
         plot <= 1'b0;
         if (step) begin
            vga_x      <= pix_x[X_W-1:0];
            vga_y      <= pix_y[Y_W-1:0];
            vga_colour <= (state == ERASE) ? BG_COLOUR : COLOUR;
            plot       <= in_bounds;
         end

         // Events while busy collapse into a single deferred move; the
         // finalise below may override this with a clear.
         if (busy && event_in) pending <= 1'b1;

         case (state)
            IDLE: begin
`ifdef SPRITE_RENDER_SKIP_EN
               if (skip_busy) begin
                  skip_busy <= 1'b0;
               end else
`endif
               if (load_level) begin
                  new_x <= obj_x;
                  new_y <= obj_y;
                  new_w <= lat_w;
                  if (lat_w != '0) begin
                     state <= DRAW;
                  end else begin
                     old_x     <= obj_x;
                     old_y     <= obj_y;
                     old_w     <= lat_w;
                     old_valid <= 1'b1;
                  end
               end else if (move || pending) begin
                  pending <= 1'b0;
                  new_x   <= obj_x;
                  new_y   <= obj_y;
                  new_w   <= lat_w;
`ifdef SPRITE_RENDER_SKIP_EN
                  if (skip_match) begin
                     skip_busy <= 1'b1;
                  end else
`endif
                  if (old_valid && (old_w != '0)) begin
                     state <= ERASE;
                  end else if (lat_w != '0) begin
                     state <= DRAW;
                  end else begin
                     // Nothing to erase and nothing to draw: just record it.
                     old_x     <= obj_x;
                     old_y     <= obj_y;
                     old_w     <= lat_w;
                     old_valid <= 1'b1;
                  end
               end
            end
            ERASE: begin
               if (step && last && (new_w != '0)) state <= DRAW;
            end
            DRAW: begin
            end
            default: state <= IDLE;
         endcase

         // Finalise: the square just drawn becomes the one to erase next time.
         // A deferred move samples the inputs now, not when it was pulsed.
         if (done) begin
            old_x     <= new_x;
            old_y     <= new_y;
            old_w     <= new_w;
            old_valid <= 1'b1;
            if (pending || event_in) begin
               pending <= 1'b0;
               new_x   <= obj_x;
               new_y   <= obj_y;
               new_w   <= lat_w;
               if (new_w != '0) begin
                  state <= ERASE;
               end else if (lat_w != '0) begin
                  state <= DRAW;
               end else begin
                  state <= IDLE;
                  old_x <= obj_x;
                  old_y <= obj_y;
                  old_w <= lat_w;
               end
            end else begin
               state <= IDLE;
            end
         end
      end
   end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Consumer end of the object-control interface: takes an object's position, width and single-cycle move pulse, and turns them into VGA pixel writes.
- On each move it erases the square at the previously drawn position in the background colour, then draws the square at the new position in the sprite colour.
- Several instances, one per player, enemy or bullet, share one VGA adapter port through an external req/gnt arbiter.

Parameters:
- COLOUR, 3'b111: sprite pixel colour.
- BG_COLOUR, 3'b000: erase colour.
- MAX_W, 15: largest accepted width. Widths above MAX_W are clamped to MAX_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- move  in  1  single-cycle pulse: the object's position has changed
- load_level  in  1  single-cycle pulse: draw at the current position with no erase
- obj_x  in  8  top-left x of the object
- obj_y  in  7  top-left y of the object
- obj_w  in  4  square width in pixels; 0 means the object is not drawn
- gnt  in  1  arbiter grant, valid in the same cycle as req
- req  out  1  request for the VGA port
- busy  out  1  high in any state other than IDLE
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- plot  out  1  write enable for the pixel on vga_x, vga_y, vga_colour

Behaviour:
- Reset values:
  - state=IDLE; req=0, busy=0, plot=0.
  - vga_x=0, vga_y=0, vga_colour=0.
  - pending=0, old_valid=0, old_x=0, old_y=0, old_w=0.
- States: IDLE, ERASE, DRAW.
- IDLE, move=1:
  - Latch obj_x, obj_y and clamped obj_w into new_x, new_y, new_w.
  - Go to ERASE if old_valid=1 and old_w!=0. Otherwise go straight to DRAW.
- IDLE, load_level=1:
  - Latch the inputs the same way and go to DRAW. No erase.
  - load_level has priority over move in the same cycle.
- ERASE:
  - Scan old square, row-major: px 0..old_w-1 inner loop, py 0..old_w-1 outer loop.
  - Pixel address is (old_x+px, old_y+py), colour BG_COLOUR.
  - After the last pixel go to DRAW with px=py=0. If new_w=0, skip DRAW and finalise.
- DRAW:
  - Same scan over new_w, colour COLOUR.
  - After the last pixel, finalise.
- Finalise:
  - old_x/old_y/old_w <= new_x/new_y/new_w; old_valid <= 1.
  - If pending=1: clear pending, re-latch the current inputs, go to ERASE.
  - Otherwise go to IDLE.
- Pixel timing:
  - req=1 whenever the state is ERASE or DRAW.
  - On a clock edge with req=1 and gnt=1, the current pixel is registered onto vga_x/vga_y/vga_colour and the scan counter advances.
  - plot is asserted for one cycle, one cycle after the granted step, so it is aligned with the registered pixel.
  - plot is forced to 0 if x>=160 or y>=120. Address arithmetic uses 9-bit x and 8-bit y so clipped pixels do not wrap to 0.
  - When gnt=0 the counter holds and plot=0 on the next cycle.
- Latency: with gnt held high, 2*w*w granted cycles from the move pulse to the last plot.
- move or load_level while busy:
  - Sets pending. Multiple events collapse into one.
  - Input values are sampled at finalise, not at the pulse.
- Width rules:
  - obj_w=0 on a move erases the old square and draws nothing. This covers a dead enemy.
  - old_w=0 skips the erase.
- Reset while busy: abort immediately, all reset values apply, next cycle has plot=0. The partially drawn frame is not repaired.

Optional Feature:
- Macro: SPRITE_RENDER_SKIP_EN.
- Defined: a move whose latched x, y and w all equal old_x, old_y, old_w returns to IDLE with no req and no plot. Cost is 1 cycle of busy.
- Undefined: the same move erases and redraws identical pixels.

Decomposition:
- Shared package holds:
  - SCREEN_W=160, SCREEN_H=120.
  - Colour width 3; coordinate widths 8 and 7.
  - The state enum.
- One sub-module, square_scanner: px/py counter with start, advance (gnt), width input and a last-pixel flag. Used in both ERASE and DRAW.

Test Plan:
- load_level with (40,30), w=3, gnt=1 -> 9 plots of colour 111 covering x 40..42, y 30..32, row-major; then busy=0.
- Move to (41,30), w=3, gnt=1 -> 9 plots of colour 000 at the old square, then 9 plots of colour 111 at x 41..43; total 18 cycles.
- Same move with gnt toggling 1,0,1,0 -> 18 plots, none lost or duplicated; plot=0 on every cycle following gnt=0.
- Second move pulse during ERASE with the input at (50,60), followed by a third pulse -> exactly one extra erase+draw, ending at (50,60).
- Move with obj_w=0 after a w=4 sprite at (158,118) -> erase plots only in-bounds pixels (158..159, 118..119), 4 plots; no draw.
- reset asserted mid-DRAW -> the next cycle has plot=0, req=0, busy=0; a subsequent move does no erase because old_valid=0.
